tpu_layer_sequencer: RTL
========================

// Module: tpu_layer_sequencer
// PURPOSE
// - Top-level scheduler for the TPU inference pass.
// - Runs the fully-connected layer engines one after another (layer 0 .. NUM_LAYERS-1). Each engine gets enable and a reset pulse.
// - Owns the shared memory address bus and the shared MultAdd operand buses. The active layer's buses are muxed through; the others are isolated (no tri-state).
// - Collects overflow from every layer and reports completion of the whole pass.
// PARAMETERS
// - NUM_LAYERS  3     number of layer engines sequenced (1..8)
// - DATA_W      1024  width of the memory word and of each MultAdd operand (128 x 8-bit)
// - ADDR_W      12    memory address width
// - TIMEOUT     4096  watchdog limit, in cycles per layer (only with TPU_SEQ_TIMEOUT_EN)
// PORTS
// - clk             in   1                 single clock, all state on posedge
// - iRst            in   1                 asynchronous, active-high reset
// - start           in   1                 1-cycle pulse; begins a pass when idle
// - abort           in   1                 synchronous abort of the running pass
// - layer_addr      in   NUM_LAYERS*ADDR_W memory address from each layer; slice i = layer i
// - layer_data1     in   NUM_LAYERS*DATA_W MultAdd operand 1 from each layer
// - layer_data2     in   NUM_LAYERS*DATA_W MultAdd operand 2 from each layer
// - layer_done      in   NUM_LAYERS        done flag from each layer
// - layer_overflow  in   NUM_LAYERS        overflow flag from each layer
// - layer_ena       out  NUM_LAYERS        one-hot enable to the layers
// - layer_rst_n     out  NUM_LAYERS        active-low synchronous reset to the layers
// - addr_to_memory  out  ADDR_W            muxed address from the active layer
// - data1_to_MultAdd out DATA_W            muxed operand 1 from the active layer
// - data2_to_MultAdd out DATA_W            muxed operand 2 from the active layer
// - active_layer    out  3                 index of the current layer
// - busy            out  1                 high from accepted start until FINISH/IDLE
// - done            out  1                 1-cycle pulse when the pass completes
// - overflow        out  1                 sticky OR of overflow from all layers this pass
// - timeout         out  1                 sticky watchdog flag
// BEHAVIOUR
// - Reset values: layer_ena=0, layer_rst_n=all 1, active_layer=0, busy=0, done=0, overflow=0, timeout=0. FSM is in IDLE.
// - FSM states:
//   - IDLE: waits for start. On start: idx=0, overflow=0, timeout=0, go to LRST.
//   - LRST (1 cycle): layer_ena[idx]=1 and layer_rst_n[idx]=0, then go to ARM.
//   - ARM: layer_ena[idx]=1, layer_rst_n=1. Waits until layer_done[idx]==0 (engine actually started). A done that is high on entry is stale and is ignored. Then go to RUN.
//   - RUN: waits for layer_done[idx]==1. On that cycle: overflow |= layer_overflow[idx], go to NEXT.
//   - NEXT (1 cycle): layer_ena=0. If idx==NUM_LAYERS-1 go to FINISH; otherwise idx++ and go to LRST.
//   - FINISH (1 cycle): done=1, busy=0 next cycle, then go to IDLE.
// - Muxes are combinational on the registered idx. There is zero added latency, so a layer's address-then-data-next-cycle protocol is preserved.
// - Muxes are valid in LRST/ARM/RUN. In any other state, addr_to_memory, data1_to_MultAdd and data2_to_MultAdd are all-zero.
// - Exactly one layer_ena bit is high at a time. Between two layers there is at least one cycle with all enables low (NEXT).
// - start while busy is ignored. A start in the same cycle as FINISH is also ignored.
// - abort in any non-IDLE state: next cycle the FSM is in IDLE, layer_ena=0, busy=0, done is not pulsed, overflow and timeout hold.
// - abort and start in the same cycle while in IDLE: abort wins; the pass does not start.
// - iRst mid-pass: immediate return to reset values; layers are disabled asynchronously through layer_ena.
// - active_layer = idx, zero-extended to 3 bits.
// CONFIGURATION
// - TPU_SEQ_TIMEOUT_EN defined: a per-layer cycle counter clears on entering LRST and counts in ARM/RUN.
//   - When the counter reaches TIMEOUT: timeout=1, layer_ena=0, go to IDLE without a done pulse.
// - TPU_SEQ_TIMEOUT_EN undefined: no counter; ARM/RUN wait indefinitely; timeout is tied to 0.
// TESTING
// - Reset, then start with 3 layers that raise done 20 cycles after the reset pulse:
//   - layer_ena goes 001 -> 010 -> 100.
//   - There is one all-zero cycle between layers.
//   - done pulses once, and busy is low afterwards.
// - Layer 1 drives layer_addr=12'h405: addr_to_memory==12'h405 only while active_layer==1; in IDLE it is 0.
// - Layer 0 holds done=1 through ARM and drops it after 3 cycles: the sequencer stays in ARM and does not advance on the stale done.
// - layer_overflow[2]=1 when layer 2's done rises: overflow==1 after the pass; it clears on the next start.
// - abort during layer 1 RUN: next cycle layer_ena==0, busy==0, and no done pulse. With start+abort together in IDLE, busy stays 0.
// - TPU_SEQ_TIMEOUT_EN defined, TIMEOUT=64, layer 0 never raises done: timeout==1 about 64 cycles after LRST, layer_ena==0, no done pulse.

Source files
------------

// File: rtl/tpu_layer_sequencer.sv
// Inference-pass scheduler: runs the layer engines in order, muxes their shared buses and collects overflow.
// Optional per-layer watchdog is enabled by defining TPU_SEQ_TIMEOUT_EN.
module tpu_layer_sequencer #(
    parameter int NUM_LAYERS = 3,
    parameter int DATA_W     = 1024,
    parameter int ADDR_W     = 12,
    parameter int TIMEOUT    = 4096
) (
    input  logic                         clk,
    input  logic                         iRst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
    input  logic [NUM_LAYERS*DATA_W-1:0] layer_data1,
    input  logic [NUM_LAYERS*DATA_W-1:0] layer_data2,
    input  logic [NUM_LAYERS-1:0]        layer_done,
    input  logic [NUM_LAYERS-1:0]        layer_overflow,
    output logic [NUM_LAYERS-1:0]        layer_ena,
    output logic [NUM_LAYERS-1:0]        layer_rst_n,
    output logic [ADDR_W-1:0]            addr_to_memory,
    output logic [DATA_W-1:0]            data1_to_MultAdd,
    output logic [DATA_W-1:0]            data2_to_MultAdd,
    output logic [2:0]                   active_layer,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow,
    output logic                         timeout
);

    if (NUM_LAYERS < 1 || NUM_LAYERS > 8) begin : g_bad_num_layers
        $error("tpu_layer_sequencer: NUM_LAYERS must be in 1..8");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("tpu_layer_sequencer: TIMEOUT must be at least 1");
    end

    localparam logic [2:0] LAST_IDX = 3'(NUM_LAYERS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LRST,
        S_ARM,
        S_RUN,
        S_NEXT,
        S_FINISH
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic       ovf_q, ovf_d;
    logic       done_sel, ovf_sel;
    logic       in_layer;

`ifdef TPU_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
`endif

    assign in_layer = (state_q == S_LRST) || (state_q == S_ARM) || (state_q == S_RUN);

    // Select the active layer's flags and buses; inactive layers are isolated by forcing zeros.
    always_comb begin
        done_sel         = 1'b0;
        ovf_sel          = 1'b0;
        layer_ena        = '0;
        layer_rst_n      = '1;
        addr_to_memory   = '0;
        data1_to_MultAdd = '0;
        data2_to_MultAdd = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (idx_q == i[2:0]) begin
                done_sel = layer_done[i];
                ovf_sel  = layer_overflow[i];
                if (in_layer) begin
                    layer_ena[i]     = 1'b1;
                    layer_rst_n[i]   = (state_q != S_LRST);
                    addr_to_memory   = layer_addr[i*ADDR_W +: ADDR_W];
                    data1_to_MultAdd = layer_data1[i*DATA_W +: DATA_W];
                    data2_to_MultAdd = layer_data2[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
`ifdef TPU_SEQ_TIMEOUT_EN
        cnt_d   = '0;
        tmo_d   = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_LRST;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
`ifdef TPU_SEQ_TIMEOUT_EN
                    tmo_d   = 1'b0;
`endif
                end
            end
            S_LRST: state_d = S_ARM;
            // A done still high from the previous run is stale; wait for the engine to drop it.
            S_ARM: begin
                if (!done_sel) state_d = S_RUN;
            end
            S_RUN: begin
                if (done_sel) begin
                    ovf_d   = ovf_q | ovf_sel;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_LRST;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
`ifdef TPU_SEQ_TIMEOUT_EN
        if (state_q == S_ARM || state_q == S_RUN) begin
            if (cnt_q == CNT_LAST) begin
                tmo_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`endif
        // Abort leaves the pass without a done pulse and keeps the sticky flags as they were.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            idx_d   = idx_q;
            ovf_d   = ovf_q;
`ifdef TPU_SEQ_TIMEOUT_EN
            tmo_d   = tmo_q;
`endif
        end
    end

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef TPU_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout = tmo_q;
`else
    assign timeout = 1'b0;
`endif

    assign active_layer = idx_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_FINISH);
    assign overflow     = ovf_q;

endmodule
